// File: rtl/hmmm_flash_loader.sv
// hmmm_flash_loader: SPI-flash boot loader streaming 16-bit Hmmm words into imem.
// Optional macro HMMM_LOADER_CHECKSUM_EN verifies a trailing sum word.
module hmmm_flash_loader #(
   parameter int          NUM_WORDS = 256,
   parameter logic [23:0] BASE_ADDR = 24'h000000,
   parameter int          CLK_DIV   = 2
) (
   input  logic        clock,
   input  logic        resetb,
   input  logic        start,
   output logic        flash_csb,
   output logic        flash_clk,
   output logic        flash_io0,
   input  logic        flash_io1,
   output logic        mem_we,
   output logic [7:0]  mem_addr,
   output logic [15:0] mem_wdata,
   output logic        busy,
   output logic        done,
   output logic        cpu_resetb
`ifdef HMMM_LOADER_CHECKSUM_EN
   ,
   output logic        checksum_ok
`endif
);

   typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, FINISH} state_t;

   localparam logic [31:0] HDR       = {8'h03, BASE_ADDR};
   localparam logic [7:0]  DIV_LAST  = 8'(CLK_DIV - 1);
   localparam logic [8:0]  LAST_WORD = 9'(NUM_WORDS - 1);

   state_t      state;
   logic        armed;
   logic [7:0]  div_cnt;
   logic [5:0]  bit_cnt;
   logic [31:0] tx_sh;
   logic [14:0] rx_sh;
   logic [8:0]  word_cnt;
   logic        tick;
   logic [15:0] rx_word;
`ifdef HMMM_LOADER_CHECKSUM_EN
   logic [15:0] sum;
`endif

   assign tick    = (div_cnt == DIV_LAST);
   assign rx_word = {rx_sh, flash_io1};

   // Reset release is registered so a start in the release cycle is ignored
   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) armed <= 1'b0;
      else         armed <= 1'b1;
   end

   // Loader FSM: SPI framing, word assembly and memory writes
   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         state      <= IDLE;
         flash_csb  <= 1'b1;
         flash_clk  <= 1'b0;
         flash_io0  <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         cpu_resetb <= 1'b0;
         div_cnt    <= '0;
         bit_cnt    <= '0;
         tx_sh      <= '0;
         rx_sh      <= '0;
         word_cnt   <= '0;
`ifdef HMMM_LOADER_CHECKSUM_EN
         sum         <= '0;
         checksum_ok <= 1'b0;
`endif
      end else begin
         mem_we <= 1'b0;
         unique case (state)
            IDLE: begin
               flash_csb <= 1'b1;
               flash_clk <= 1'b0;
               if (start && armed) begin
                  busy       <= 1'b1;
                  done       <= 1'b0;
                  cpu_resetb <= 1'b0;
                  word_cnt   <= '0;
                  bit_cnt    <= '0;
                  div_cnt    <= '0;
                  flash_csb  <= 1'b0;
                  flash_io0  <= HDR[31];
                  tx_sh      <= {HDR[30:0], 1'b0};
`ifdef HMMM_LOADER_CHECKSUM_EN
                  sum         <= '0;
                  checksum_ok <= 1'b0;
`endif
                  state      <= CMD;
               end
            end
            CMD, ADDR: begin
               div_cnt <= tick ? 8'd0 : div_cnt + 8'd1;
               if (tick) begin
                  flash_clk <= ~flash_clk;
                  if (!flash_clk) begin
                     bit_cnt <= bit_cnt + 6'd1;
                  end else if (bit_cnt == 6'd32) begin
                     // header fully sent; flash now streams data
                     bit_cnt   <= '0;
                     flash_io0 <= 1'b0;
                     state     <= DATA;
                  end else begin
                     flash_io0 <= tx_sh[31];
                     tx_sh     <= {tx_sh[30:0], 1'b0};
                     if (bit_cnt == 6'd8) state <= ADDR;
                  end
               end
            end
            DATA: begin
               div_cnt <= tick ? 8'd0 : div_cnt + 8'd1;
               if (tick) begin
                  flash_clk <= ~flash_clk;
                  if (!flash_clk) begin
                     rx_sh   <= rx_word[14:0];
                     bit_cnt <= bit_cnt + 6'd1;
                     if (bit_cnt == 6'd15) begin
                        bit_cnt  <= '0;
                        word_cnt <= word_cnt + 9'd1;
`ifdef HMMM_LOADER_CHECKSUM_EN
                        if (word_cnt > LAST_WORD) begin
                           checksum_ok <= (rx_word == sum);
                           state       <= FINISH;
                        end else begin
                           mem_we    <= 1'b1;
                           mem_addr  <= word_cnt[7:0];
                           mem_wdata <= rx_word;
                           sum       <= sum + rx_word;
                        end
`else
                        mem_we    <= 1'b1;
                        mem_addr  <= word_cnt[7:0];
                        mem_wdata <= rx_word;
                        if (word_cnt == LAST_WORD) state <= FINISH;
`endif
                     end
                  end
               end
            end
            FINISH: begin
               div_cnt <= tick ? 8'd0 : div_cnt + 8'd1;
               if (tick) begin
                  if (flash_clk) begin
                     flash_clk <= 1'b0;
                  end else begin
                     flash_csb <= 1'b1;
                     busy      <= 1'b0;
                     done      <= 1'b1;
`ifdef HMMM_LOADER_CHECKSUM_EN
                     cpu_resetb <= checksum_ok;
`else
                     cpu_resetb <= 1'b1;
`endif
                     state     <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/hmmm_flash_loader.md
Name: hmmm_flash_loader

Overview:
SPI-flash boot loader for the Hmmm core in the user project area. On a start request it acts as SPI initiator: it issues a standard READ (0x03) to the external flash and streams NUM_WORDS 16-bit Hmmm instructions into the core's instruction memory. The core is held in reset until the load completes. It is the initiator for the spiflash responder the chip-level bench already instantiates.

Parameters:
- NUM_WORDS, 256: words to load, range 1..256; written to mem_addr 0..NUM_WORDS-1.
- BASE_ADDR, 24'h000000: flash byte address of word 0.
- CLK_DIV, 2: system clocks per SCK half-period, minimum 1.

Ports:
- clock, in, 1: system clock.
- resetb, in, 1: asynchronous active-low reset.
- start, in, 1: single-cycle load request.
- flash_csb, out, 1: flash chip select, active low.
- flash_clk, out, 1: SCK, SPI mode 0.
- flash_io0, out, 1: MOSI.
- flash_io1, in, 1: MISO.
- mem_we, out, 1: instruction-memory write strobe, one cycle per word.
- mem_addr, out, 8: word address.
- mem_wdata, out, 16: instruction word.
- busy, out, 1: load in progress.
- done, out, 1: sticky load-complete flag.
- cpu_resetb, out, 1: active-low reset to the Hmmm core.

Behaviour:
- Reset values:
  - flash_csb=1, flash_clk=0, flash_io0=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, cpu_resetb=0.
  - Reset is asserted asynchronously and released synchronously.
- States: IDLE -> CMD -> ADDR -> DATA -> FINISH -> IDLE.
- IDLE:
  - flash_csb=1, flash_clk=0.
  - When start=1: busy=1, done=0, cpu_resetb=0, word counter=0, then go to CMD.
  - start is ignored in every state other than IDLE.
- SPI framing:
  - flash_csb falls on the cycle after start is accepted.
  - flash_io0 is valid one full half-period before the first rising SCK edge.
  - SCK toggles every CLK_DIV clocks.
  - MOSI changes only while SCK is low; flash_io1 is sampled on the clock that drives the rising SCK edge.
- CMD: shift 8'h03 out MSB first (8 SCK cycles).
- ADDR: shift BASE_ADDR out MSB first (24 SCK cycles), then go to DATA.
- DATA:
  - Shift in 16 bits per word, MSB first, so word = {byte at 2k, byte at 2k+1}.
  - On the clock after the 16th sample: mem_we=1 for exactly one cycle, mem_addr = word index, mem_wdata = assembled word.
  - SCK continues without a gap (continuous read); the shift register is copied before the next bit arrives.
  - After word NUM_WORDS-1 is written, go to FINISH.
- FINISH:
  - flash_clk=0, then flash_csb=1 after one half-period.
  - Then busy=0, done=1, cpu_resetb=1, return to IDLE.
- Totals:
  - SCK cycles per load = 32 + 16*NUM_WORDS.
  - Exactly NUM_WORDS mem_we pulses; never 0 or NUM_WORDS+1.
- Word counter is 9 bits so NUM_WORDS=256 terminates correctly; mem_addr is the low 8 bits.
- done stays 1 until the next accepted start.
- cpu_resetb stays 1 after a completed load until the next start or reset.
- resetb asserted mid-load: all outputs return to reset values immediately (csb high, no further mem_we); a partial load is not resumed.
- start in the same cycle that resetb is released is ignored.

Optional Feature:
HMMM_LOADER_CHECKSUM_EN:
- When defined:
  - After the last instruction, one extra 16-bit word is read (not written to memory).
  - It is compared against the modulo-2^16 sum of all loaded words.
  - Adds output checksum_ok (1 bit, reset 0), valid when done=1.
  - cpu_resetb is released only if checksum_ok=1; on mismatch done=1, checksum_ok=0, cpu_resetb stays 0.
- When undefined: no extra word, no checksum_ok port, cpu_resetb follows done.

Test Plan:
1. NUM_WORDS=4, BASE_ADDR=0, flash holds 01 23 45 67 89 AB CD EF, start pulse -> MOSI carries 0x03,0x000000; mem writes (0,0x0123),(1,0x4567),(2,0x89AB),(3,0xCDEF); done=1, cpu_resetb=1, flash_csb=1; total SCK count 96.
2. BASE_ADDR=24'h100000, CLK_DIV=3 -> MOSI address bits 0x100000; SCK high and low each 3 clocks; data taken from flash offset 0x100000.
3. start re-pulsed during DATA and held high for 5 cycles -> no restart, exactly NUM_WORDS mem_we pulses, single csb low window.
4. resetb low after word 1 of 4 -> same cycle flash_csb=1, busy=0, cpu_resetb=0; no further mem_we; a fresh start reloads from address 0.
5. NUM_WORDS=256 -> last write at mem_addr 0xFF, 256 pulses total, no wrap write to address 0.
6. HMMM_LOADER_CHECKSUM_EN, words 0x0001,0x0002 + checksum 0x0003 -> checksum_ok=1, cpu_resetb=1; with checksum 0x0004 -> checksum_ok=0, cpu_resetb=0, done=1.
